// File: rtl/usb_ddr3_stream_arbiter_pkg.sv
// Shared definitions for the USB/secondary-stream to DDR3 write arbiter:
// FSM state encodings, one-hot grant constants and the round-robin pick.
`timescale 1ns/1ps
package usb_ddr3_stream_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_S0   = 2'b01;
  localparam logic [1:0] GNT_S1   = 2'b10;

  // On contention the source that did not finish the previous packet wins.
  function automatic logic [1:0] rr_pick(input logic v0, input logic v1,
                                         input logic [1:0] last_grant);
    if (v0 && v1) return (last_grant == GNT_S0) ? GNT_S1 : GNT_S0;
    if (v0) return GNT_S0;
    if (v1) return GNT_S1;
    return GNT_NONE;
  endfunction

endpackage

// File: rtl/usb_ddr3_stream_arbiter_axis_hold_reg.sv
// Single-register AXI-Stream output stage. The register accepts a new beat
// whenever it is empty or its current beat is being taken downstream.
`timescale 1ns/1ps
module axis_hold_reg (
  input  logic       clock,
  input  logic       arst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_keep,
  input  logic       in_last,
  output logic       load,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_keep,
  output logic       out_last
);

  assign load = !out_valid || out_ready;

  // Capture the offered beat (or an empty slot) whenever the register can move.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= in_valid;
      out_data  <= in_data;
      out_keep  <= in_keep;
      out_last  <= in_last;
    end
  end

endmodule

// File: rtl/usb_ddr3_stream_arbiter.sv
// Packet-granular 2:1 AXI-Stream arbiter in front of the DDR3 write stream.
// Source 0 is USB bulk-OUT, source 1 a secondary capture stream. A stall
// watchdog and a length limit keep the DDR3 path from wedging.
// Build option: define ARB_FIXED_PRIORITY_EN to make source 0 always win
// contention instead of round-robin.
`timescale 1ns/1ps
module usb_ddr3_stream_arbiter
  import usb_ddr3_stream_arbiter_pkg::*;
#(
  parameter int MAX_PACKET_LENGTH = 512,
  parameter int STALL_CYCLES      = 1024,
  parameter int LBITS             = 10,
  parameter int TBITS             = 11
) (
  input  logic       clock,
  input  logic       arst_n,
  input  logic       s0_tvalid,
  output logic       s0_tready,
  input  logic       s0_tkeep,
  input  logic       s0_tlast,
  input  logic [7:0] s0_tdata,
  input  logic       s1_tvalid,
  output logic       s1_tready,
  input  logic       s1_tkeep,
  input  logic       s1_tlast,
  input  logic [7:0] s1_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tkeep,
  output logic       m_tlast,
  output logic [7:0] m_tdata,
  output logic [1:0] grant_o,
  output logic       abort_o,
  output logic       oversize_o
);

  logic [1:0]       state;
  logic [1:0]       grant;
  logic [1:0]       pick;
  logic [LBITS-1:0] byte_cnt;
  logic [TBITS-1:0] stall_cnt;
  logic             abort_q;
  logic             oversize_q;
  logic             load;
  logic             hold_valid;
  logic [7:0]       hold_data;
  logic             hold_keep;
  logic             hold_last;

  // The owner's signals; grant is never 00 outside IDLE.
  logic       own_valid, own_keep, own_last;
  logic [7:0] own_data;
  assign own_valid = grant[1] ? s1_tvalid : s0_tvalid;
  assign own_keep  = grant[1] ? s1_tkeep  : s0_tkeep;
  assign own_last  = grant[1] ? s1_tlast  : s0_tlast;
  assign own_data  = grant[1] ? s1_tdata  : s0_tdata;

  logic xfer_acc, drain_acc, len_hit, stall_hit;
  assign xfer_acc  = (state == ST_XFER) && load && own_valid;
  assign drain_acc = (state == ST_DRAIN) && own_valid;
  assign len_hit   = (byte_cnt == LBITS'(MAX_PACKET_LENGTH - 1));
  assign stall_hit = (stall_cnt == TBITS'(STALL_CYCLES - 1));

  // DRAIN swallows the owner's beats regardless of the output register.
  assign s0_tready = grant[0] && (((state == ST_XFER) && load) || (state == ST_DRAIN));
  assign s1_tready = grant[1] && (((state == ST_XFER) && load) || (state == ST_DRAIN));

  assign grant_o    = grant;
  assign abort_o    = abort_q;
  assign oversize_o = oversize_q;

`ifdef ARB_FIXED_PRIORITY_EN
  assign pick = s0_tvalid ? GNT_S0 : (s1_tvalid ? GNT_S1 : GNT_NONE);
`else
  logic [1:0] last_grant;

  // Remember who completed the last packet; reset favours source 0 next.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n)                  last_grant <= GNT_S1;
    else if (xfer_acc && own_last) last_grant <= grant;
  end

  assign pick = rr_pick(s0_tvalid, s1_tvalid, last_grant);
`endif

  // Select what is offered to the output register in each state.
  always_comb begin
    hold_valid = 1'b0;
    hold_data  = '0;
    hold_keep  = 1'b0;
    hold_last  = 1'b0;
    case (state)
      ST_XFER: begin
        hold_valid = own_valid;
        hold_data  = own_data;
        hold_keep  = own_keep;
        hold_last  = own_last || len_hit;
      end
      ST_ABORT: begin
        hold_valid = 1'b1;
        hold_last  = 1'b1;
      end
      default: ;
    endcase
  end

  // Arbitration FSM with packet-length and stall counters.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      state      <= ST_IDLE;
      grant      <= GNT_NONE;
      byte_cnt   <= '0;
      stall_cnt  <= '0;
      abort_q    <= 1'b0;
      oversize_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick != GNT_NONE) begin
            grant     <= pick;
            state     <= ST_XFER;
            byte_cnt  <= '0;
            stall_cnt <= '0;
          end
        end
        ST_XFER: begin
          if (xfer_acc) begin
            byte_cnt  <= byte_cnt + LBITS'(1);
            stall_cnt <= '0;
            if (own_last) begin
              grant <= GNT_NONE;
              state <= ST_IDLE;
            end else if (len_hit) begin
              oversize_q <= 1'b1;
              state      <= ST_DRAIN;
            end
          end else if (!own_valid) begin
            if (stall_hit) begin
              stall_cnt <= '0;
              state     <= ST_ABORT;
            end else begin
              stall_cnt <= stall_cnt + TBITS'(1);
            end
          end
        end
        ST_ABORT: begin
          if (load) begin
            abort_q   <= 1'b1;
            stall_cnt <= '0;
            state     <= ST_DRAIN;
          end
        end
        default: begin
          if (drain_acc) begin
            stall_cnt <= '0;
            if (own_last) begin
              grant <= GNT_NONE;
              state <= ST_IDLE;
            end
          end else if (stall_hit) begin
            stall_cnt <= '0;
            grant     <= GNT_NONE;
            state     <= ST_IDLE;
          end else begin
            stall_cnt <= stall_cnt + TBITS'(1);
          end
        end
      endcase
    end
  end

  axis_hold_reg u_out (
    .clock     (clock),
    .arst_n    (arst_n),
    .in_valid  (hold_valid),
    .in_data   (hold_data),
    .in_keep   (hold_keep),
    .in_last   (hold_last),
    .load      (load),
    .out_ready (m_tready),
    .out_valid (m_tvalid),
    .out_data  (m_tdata),
    .out_keep  (m_tkeep),
    .out_last  (m_tlast)
  );

endmodule

// File: doc/usb_ddr3_stream_arbiter.md
Name: usb_ddr3_stream_arbiter

Overview:
- Packet-granular 2:1 AXI-Stream arbiter feeding the single DDR3 write stream (`ddr3_top` `s_*` port).
- Source 0: USB bulk-OUT (`blky_*`). Source 1: a secondary byte stream (logger/telemetry capture).
- Grants are held for a whole packet, through `tlast`. A stall watchdog closes any packet whose source goes silent mid-transfer, so the DDR3 path cannot wedge.
- Sits in the USB clock domain, between `usb_ulpi_core` and `ddr3_top`.

Parameters:
- MAX_PACKET_LENGTH, 512, max bytes per packet; a longer packet is force-terminated.
- STALL_CYCLES, 1024, idle cycles mid-packet before abort.
- LBITS, 10, packet byte-counter width; must satisfy 2^LBITS > MAX_PACKET_LENGTH.
- TBITS, 11, stall-counter width; must satisfy 2^TBITS > STALL_CYCLES.

Ports:
- clock, in, 1, USB/bus clock.
- arst_n, in, 1, asynchronous active-low reset.
- s0_tvalid / s0_tready / s0_tkeep / s0_tlast, in/out/in/in, 1 each, source 0 handshake.
- s0_tdata, in, 8, source 0 byte.
- s1_tvalid / s1_tready / s1_tkeep / s1_tlast, in/out/in/in, 1 each, source 1 handshake.
- s1_tdata, in, 8, source 1 byte.
- m_tvalid / m_tready / m_tkeep / m_tlast, out/in/out/out, 1 each, to DDR3 `s_*`.
- m_tdata, out, 8, output byte.
- grant_o, out, 2, one-hot current owner; 00 when idle.
- abort_o, out, 1, one-cycle pulse when a packet is force-terminated.
- oversize_o, out, 1, sticky; set when a length limit was hit; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; `last_grant` = source 1, so source 0 wins first.
- Output stage: a single register (`m_*`). Loads when `!m_tvalid || m_tready`; this is the "load" condition below.
- `sN_tready` = load && state==XFER && grant_o[N]. The non-granted source always sees `tready`=0.
- Latency: a source beat accepted at cycle t appears on `m_*` at t+1.
- IDLE:
  - If exactly one `sN_tvalid` is high, grant it.
  - If both are high, grant the source opposite to `last_grant` (round-robin).
  - Grant is registered, so first acceptance happens the cycle after the grant. Go to XFER; clear both counters.
- XFER:
  - Each accepted beat increments the byte counter and clears the stall counter.
  - On an accepted beat with `tlast`=1: set `last_grant` to the owner, go to IDLE (at least one idle cycle between packets).
  - If the byte counter reaches MAX_PACKET_LENGTH-1 with `tlast`=0: force `m_tlast`=1 on that beat, set oversize_o, go to DRAIN.
  - If the owner's `tvalid` is low, increment the stall counter. At STALL_CYCLES go to ABORT.
- ABORT:
  - When load is true, emit one beat with `m_tvalid`=1, `m_tlast`=1, `m_tkeep`=0, `m_tdata`=0.
  - Pulse abort_o in that cycle. Go to DRAIN.
- DRAIN:
  - Owner's `tready` forced to 1; beats are discarded and not forwarded.
  - Leave for IDLE on a discarded beat with `tlast`=1, or after STALL_CYCLES further idle cycles.
- `tkeep` passes through unmodified in XFER.
- `m_tready` low: the output register holds and source `tready` falls.
- Sources must not drop `tvalid` once asserted. Arbitration samples only in IDLE.
- A reset mid-packet drops all state. The downstream sees the partial packet without `tlast`; DDR3 side resync is the system reset's job.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: in IDLE, source 0 always wins when both are valid. `last_grant` is unused; source 1 can starve.
- Undefined: round-robin as above.

Decomposition:
- Shared package/header (`usb_ddr3_defs`) holds the state encodings (IDLE/XFER/ABORT/DRAIN) and the one-hot grant constants.
- One natural sub-module: `axis_hold_reg`, the single-register output stage with the load rule.
- The arbiter FSM and counters stay in the top module.

Test Plan:
- Source 0 only, 4-byte packet A0..A3 with `m_tready`=1: `grant_o`=01 one cycle after `s0_tvalid`; `m_*` carries A0..A3 with `tlast` on A3; `grant_o` returns to 00.
- Both sources valid from reset, each sending 3-byte packets continuously: outputs alternate s0, s1, s0, s1. With ARB_FIXED_PRIORITY_EN defined, only s0 packets appear.
- `m_tready` toggled 1,0,1,0 during an 8-byte packet: all 8 bytes delivered in order, none lost or duplicated; source `tready` is 0 whenever the register is full and stalled.
- Source 1 sends 2 bytes then drops `tvalid` for 1024 cycles: extra beat with `tkeep`=0, `tlast`=1; abort_o pulses once; DRAIN discards subsequent s1 bytes through `tlast`.
- Source 0 sends 600 bytes with no `tlast`, MAX_PACKET_LENGTH=512: byte 512 carries `m_tlast`=1; oversize_o=1 and stays set; remaining 88 bytes discarded.
- `arst_n` pulsed low mid-packet: all outputs 0 immediately; after release, the next arbitration favours source 0.
